// File: rtl/peripheral_ahb3_verilog_pkg.sv
// Shared AHB3-Lite encodings used by the AHB3 masters, memories and peripherals.
package peripheral_ahb3_verilog_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [2:0] HSIZE_BYTE  = 3'b000;
    localparam logic [2:0] HSIZE_HWORD = 3'b001;
    localparam logic [2:0] HSIZE_WORD  = 3'b010;
    localparam logic [2:0] HSIZE_DWORD = 3'b011;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

endpackage

// File: rtl/mpsoc_ahb3_master_port.sv
// AHB3-Lite master port: turns valid/ack requests into pipelined SINGLE
// transfers (address phase of k+1 overlaps data phase of k) and returns one
// in-order response per request.
module mpsoc_ahb3_master_port
    import peripheral_ahb3_verilog_pkg::*;
#(
    parameter int unsigned PLEN      = 8,
    parameter int unsigned XLEN      = 32,
    parameter logic [3:0]  HPROT_VAL = 4'b0011
) (
    input  logic            HCLK,
    input  logic            HRESET,

    input  logic            req_i,
    output logic            req_ack_o,
    input  logic [PLEN-1:0] req_addr_i,
    input  logic            req_we_i,
    input  logic [2:0]      req_size_i,
    input  logic [XLEN-1:0] req_wdata_i,

    output logic            rsp_valid_o,
    output logic [XLEN-1:0] rsp_rdata_o,
    output logic            rsp_err_o,

    output logic [PLEN-1:0] HADDR,
    output logic [XLEN-1:0] HWDATA,
    output logic            HWRITE,
    output logic [2:0]      HSIZE,
    output logic [2:0]      HBURST,
    output logic [3:0]      HPROT,
    output logic [1:0]      HTRANS,
    output logic            HMASTLOCK,
    input  logic [XLEN-1:0] HRDATA,
    input  logic            HREADY,
    input  logic            HRESP
);

    // Natural alignment plus a transfer no wider than the data bus.
    function automatic logic is_aligned(input logic [PLEN-1:0] addr, input logic [2:0] size);
        logic [PLEN-1:0] mask;
        mask = (PLEN'(1) << size) - PLEN'(1);
        return ((addr & mask) == '0) && ((32'd8 << size) <= 32'(XLEN));
    endfunction

    // Address-phase stage
    logic            ap_valid_q, ap_valid_d;
    logic [PLEN-1:0] ap_addr_q,  ap_addr_d;
    logic            ap_we_q,    ap_we_d;
    logic [2:0]      ap_size_q,  ap_size_d;
    logic [XLEN-1:0] ap_wdata_q, ap_wdata_d;

    // Data-phase stage
    logic            dp_valid_q, dp_valid_d;
    logic            dp_we_q,    dp_we_d;
    logic [XLEN-1:0] dp_wdata_q, dp_wdata_d;

    // Response register
    logic            rsp_valid_q, rsp_valid_d;
    logic [XLEN-1:0] rsp_rdata_q, rsp_rdata_d;
    logic            rsp_err_q,   rsp_err_d;

    logic aligned;
    logic acc_ok;
    logic acc_mis;
    logic ap_adv;
    logic dp_done;

    // Request acceptance and next-state of both pipeline stages and the response.
    always_comb begin
        aligned = is_aligned(req_addr_i, req_size_i);
        ap_adv  = ap_valid_q & HREADY;
        dp_done = dp_valid_q & HREADY;
        acc_ok  = ~HRESET & req_i & aligned & (~ap_valid_q | HREADY);
        // Misaligned requests wait for an empty pipeline so responses stay in order.
        acc_mis = ~HRESET & req_i & ~aligned & ~ap_valid_q & ~dp_valid_q;
        req_ack_o = acc_ok | acc_mis;

        ap_valid_d = ap_valid_q;
        ap_addr_d  = ap_addr_q;
        ap_we_d    = ap_we_q;
        ap_size_d  = ap_size_q;
        ap_wdata_d = ap_wdata_q;
        if (acc_ok) begin
            ap_valid_d = 1'b1;
            ap_addr_d  = req_addr_i;
            ap_we_d    = req_we_i;
            ap_size_d  = req_size_i;
            ap_wdata_d = req_wdata_i;
        end else if (ap_adv) begin
            ap_valid_d = 1'b0;
        end

        dp_valid_d = dp_valid_q;
        dp_we_d    = dp_we_q;
        dp_wdata_d = dp_wdata_q;
        if (HREADY) begin
            dp_valid_d = ap_valid_q;
            dp_we_d    = ap_we_q;
            dp_wdata_d = ap_wdata_q;
        end

        rsp_valid_d = dp_done | acc_mis;
        rsp_err_d   = acc_mis | (dp_done & (HRESP == HRESP_ERROR));
        rsp_rdata_d = (dp_done & ~dp_we_q & (HRESP == HRESP_OKAY)) ? HRDATA : '0;
    end

    // State registers with synchronous reset; reset flushes both stages and any response.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            ap_valid_q  <= 1'b0;
            ap_addr_q   <= '0;
            ap_we_q     <= 1'b0;
            ap_size_q   <= HSIZE_BYTE;
            ap_wdata_q  <= '0;
            dp_valid_q  <= 1'b0;
            dp_we_q     <= 1'b0;
            dp_wdata_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            ap_valid_q  <= ap_valid_d;
            ap_addr_q   <= ap_addr_d;
            ap_we_q     <= ap_we_d;
            ap_size_q   <= ap_size_d;
            ap_wdata_q  <= ap_wdata_d;
            dp_valid_q  <= dp_valid_d;
            dp_we_q     <= dp_we_d;
            dp_wdata_q  <= dp_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Bus outputs come straight from the stage registers.
    assign HTRANS    = ap_valid_q ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign HADDR     = ap_addr_q;
    assign HWRITE    = ap_we_q;
    assign HSIZE     = ap_size_q;
    assign HWDATA    = dp_wdata_q;
    assign HBURST    = HBURST_SINGLE;
    assign HPROT     = HPROT_VAL;
    assign HMASTLOCK = 1'b0;

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;

endmodule
